// File: rtl/histeq_frame_sequencer.sv
// histeq_frame_sequencer: frame-level controller for the histogram equalization
// core. It accepts a start command and issues the core start pulse. It then
// watches both AXI-Stream taps to check beat counts and TLAST framing, and
// reports busy/done/err status plus a completion interrupt.
// Optional build macro HISTEQ_SEQ_TIMEOUT_EN adds a stream-activity watchdog.
// This macro enables the TIMEOUT_CYCLES parameter and error code 4.

module histeq_frame_sequencer
`ifdef HISTEQ_SEQ_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd16777216
)
`endif
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_start,
    input  logic [31:0] cmd_total_pixels,
    input  logic        cmd_abort,
    output logic        core_start,
    output logic [31:0] core_total_pixels,
    input  logic        s_tvalid,
    input  logic        s_tready,
    input  logic        s_tlast,
    input  logic        m_tvalid,
    input  logic        m_tready,
    input  logic        m_tlast,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [31:0] in_count,
    output logic [31:0] out_count,
    output logic        irq
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [2:0] CODE_ZERO_SIZE = 3'd1;
    localparam logic [2:0] CODE_IN_FRAME  = 3'd2;
    localparam logic [2:0] CODE_OUT_FRAME = 3'd3;
    localparam logic [2:0] CODE_TIMEOUT   = 3'd4;
    localparam logic [2:0] CODE_ABORT     = 3'd5;

    state_t      state;
    state_t      state_next;
    logic        active;
    logic        in_beat;
    logic        out_beat;
    logic        in_err;
    logic        out_err;
    logic        timeout;
    logic        accept;
    logic        fail;
    logic [2:0]  fail_code;
    logic        finish;
    logic [31:0] last_idx;
    logic [31:0] in_next;
    logic [31:0] out_next;

    // Beat qualification and framing checks against the latched frame size
    always_comb begin
        active   = (state == S_ARM) || (state == S_RUN);
        in_beat  = s_tvalid & s_tready;
        out_beat = m_tvalid & m_tready;
        last_idx = core_total_pixels - 32'd1;
        in_next  = in_count + {31'd0, in_beat};
        out_next = out_count + {31'd0, out_beat};
        // A beat is bad when it exceeds the frame or when its TLAST does not
        // match the "this is the final index" condition.
        in_err   = in_beat  && ((in_count  >= core_total_pixels) ||
                                (s_tlast != (in_count  == last_idx)));
        out_err  = out_beat && ((out_count >= core_total_pixels) ||
                                (m_tlast != (out_count == last_idx)));
    end

`ifdef HISTEQ_SEQ_TIMEOUT_EN
    logic [31:0] wd_count;

    // Watchdog: restarts on ARM entry or any stream beat and counts idle RUN cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_count <= '0;
        end else if ((state_next == S_ARM) || in_beat || out_beat) begin
            wd_count <= '0;
        end else if (state == S_RUN) begin
            wd_count <= wd_count + 32'd1;
        end
    end

    assign timeout = (state == S_RUN) && !in_beat && !out_beat &&
                     (wd_count == TIMEOUT_CYCLES - 32'd1);
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: commands, error priority (lowest code wins), completion
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        fail       = 1'b0;
        fail_code  = '0;
        finish     = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (cmd_start && !cmd_abort) begin
                    accept = 1'b1;
                    if (cmd_total_pixels == '0) begin
                        fail       = 1'b1;
                        fail_code  = CODE_ZERO_SIZE;
                        state_next = S_ERROR;
                    end else begin
                        state_next = S_ARM;
                    end
                end
            end
            S_ARM, S_RUN: begin
                if (in_err) begin
                    fail      = 1'b1;
                    fail_code = CODE_IN_FRAME;
                end else if (out_err) begin
                    fail      = 1'b1;
                    fail_code = CODE_OUT_FRAME;
                end else if (timeout) begin
                    fail      = 1'b1;
                    fail_code = CODE_TIMEOUT;
                end else if (cmd_abort) begin
                    fail      = 1'b1;
                    fail_code = CODE_ABORT;
                end
                if (fail) begin
                    state_next = S_ERROR;
                end else if ((in_next == core_total_pixels) &&
                             (out_next == core_total_pixels)) begin
                    finish     = 1'b1;
                    state_next = S_DONE;
                end else begin
                    state_next = S_RUN;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = active;

    // Registered outputs: start pulse, frame size, sticky status, beat counters, irq
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_start        <= 1'b0;
            core_total_pixels <= '0;
            done              <= 1'b0;
            err               <= 1'b0;
            err_code          <= '0;
            in_count          <= '0;
            out_count         <= '0;
            irq               <= 1'b0;
        end else begin
            core_start <= accept && (cmd_total_pixels != '0);
            irq        <= fail || finish;
            if (accept) begin
                done      <= 1'b0;
                err       <= 1'b0;
                err_code  <= '0;
                in_count  <= '0;
                out_count <= '0;
                if (cmd_total_pixels != '0) begin
                    core_total_pixels <= cmd_total_pixels;
                end
            end
            if (active) begin
                in_count  <= in_next;
                out_count <= out_next;
            end
            // Placed after the acceptance clear so a zero-size start lands as code 1
            if (fail) begin
                err      <= 1'b1;
                err_code <= fail_code;
            end
            if (finish) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_histeq_frame_sequencer.sv
// tb_histeq_frame_sequencer: scoreboard bench for histeq_frame_sequencer.
// Each test pushes its expected final status record. The irq monitor then pops
// that record and compares it against the status outputs.

module tb_histeq_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_start = 1'b0;
    logic [31:0] cmd_total_pixels = '0;
    logic        cmd_abort = 1'b0;
    logic        core_start;
    logic [31:0] core_total_pixels;
    logic        s_tvalid = 1'b0;
    logic        s_tready = 1'b1;
    logic        s_tlast = 1'b0;
    logic        m_tvalid = 1'b0;
    logic        m_tready = 1'b1;
    logic        m_tlast = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  err_code;
    logic [31:0] in_count;
    logic [31:0] out_count;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        done;
        logic        err;
        logic [2:0]  code;
        logic [31:0] ic;
        logic [31:0] oc;
    } exp_t;

    exp_t sb[$];

`ifdef HISTEQ_SEQ_TIMEOUT_EN
    histeq_frame_sequencer #(.TIMEOUT_CYCLES(100)) dut (
`else
    histeq_frame_sequencer dut (
`endif
        .clk(clk), .reset_n(reset_n),
        .cmd_start(cmd_start), .cmd_total_pixels(cmd_total_pixels), .cmd_abort(cmd_abort),
        .core_start(core_start), .core_total_pixels(core_total_pixels),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .in_count(in_count), .out_count(out_count), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every irq must match the oldest expected status record
    always @(negedge clk) begin
        if (reset_n && irq) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_irq", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_done",      done,      e.done);
                check("sb_err",       err,       e.err);
                check("sb_err_code",  err_code,  e.code);
                check("sb_in_count",  in_count,  e.ic);
                check("sb_out_count", out_count, e.oc);
            end
        end
    end

    // One cycle of stream activity; valids/lasts drop again afterwards
    task automatic step(input logic sv, input logic sl, input logic mv, input logic ml);
        s_tvalid = sv; s_tlast = sl; m_tvalid = mv; m_tlast = ml;
        @(negedge clk);
        s_tvalid = 1'b0; s_tlast = 1'b0; m_tvalid = 1'b0; m_tlast = 1'b0;
    endtask

    // Issue a start; returns at the negedge of the following cycle (ARM for non-zero)
    task automatic start(input logic [31:0] total);
        cmd_start = 1'b1;
        cmd_total_pixels = total;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic wait_irq(input int max_cycles);
        for (int i = 0; i < max_cycles && !irq; i++) @(negedge clk);
        check("irq_seen", irq, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_core_start", core_start, 0);
        check("rst_total", core_total_pixels, 0);
        check("rst_status", {done, err, err_code, irq}, 0);
        check("rst_counts", in_count | out_count, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Normal 16-pixel frame
        sb.push_back('{done: 1'b1, err: 1'b0, code: 3'd0, ic: 32'd16, oc: 32'd16});
        start(32'd16);
        check("t1_core_start_arm", core_start, 1);
        check("t1_busy_arm", busy, 1);
        check("t1_total", core_total_pixels, 16);
        step(0, 0, 0, 0);
        check("t1_core_start_once", core_start, 0);
        check("t1_busy_run", busy, 1);
        s_tvalid = 1'b1; s_tready = 1'b0; m_tvalid = 1'b1; m_tready = 1'b0;
        @(negedge clk);
        s_tvalid = 1'b0; s_tready = 1'b1; m_tvalid = 1'b0; m_tready = 1'b1;
        check("t1_stall_no_count", in_count + out_count, 0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("t1_not_done_early", done, 0);
            step(1, i == 15, 1, i == 15);
        end
        check("t1_irq", irq, 1);
        check("t1_done", done, 1);
        check("t1_busy_done", busy, 0);
        step(1, 1, 0, 0);
        check("t1_irq_one_cycle", irq, 0);
        check("t1_ignore_beat_done", in_count, 16);
        check("t1_done_sticky", done, 1);

        // Zero-size start
        sb.push_back('{done: 1'b0, err: 1'b1, code: 3'd1, ic: 32'd0, oc: 32'd0});
        start(32'd0);
        check("t2_irq", irq, 1);
        check("t2_no_core_start", core_start, 0);
        check("t2_code", err_code, 1);
        @(negedge clk);
        check("t2_irq_one_cycle", irq, 0);
        check("t2_no_core_start_late", core_start, 0);

        // Early s_tlast on input beat 5
        sb.push_back('{done: 1'b0, err: 1'b1, code: 3'd2, ic: 32'd5, oc: 32'd0});
        start(32'd8);
        for (int i = 0; i < 5; i++) begin
            check("t3_no_err_before", err, 0);
            step(1, i == 4, 0, 0);
        end
        check("t3_code", err_code, 2);
        check("t3_in_count", in_count, 5);

        // Missing m_tlast on output beat 8
        sb.push_back('{done: 1'b0, err: 1'b1, code: 3'd3, ic: 32'd8, oc: 32'd8});
        start(32'd8);
        for (int i = 0; i < 8; i++) step(1, i == 7, 1, 0);
        check("t4_code", err_code, 3);
        check("t4_done", done, 0);

        // Simultaneous start+abort mid-frame, then a clean restart
        sb.push_back('{done: 1'b0, err: 1'b1, code: 3'd5, ic: 32'd3, oc: 32'd3});
        start(32'd20);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0);
        cmd_start = 1'b1; cmd_abort = 1'b1; cmd_total_pixels = 32'd5;
        @(negedge clk);
        cmd_start = 1'b0; cmd_abort = 1'b0;
        check("t5_code", err_code, 5);
        check("t5_start_dropped", core_total_pixels, 20);
        check("t5_no_core_start", core_start, 0);
        sb.push_back('{done: 1'b1, err: 1'b0, code: 3'd0, ic: 32'd4, oc: 32'd4});
        start(32'd4);
        check("t5_cleared", {done, err, err_code}, 0);
        check("t5_cleared_count", in_count, 0);
        for (int i = 0; i < 4; i++) step(1, i == 3, 1, i == 3);
        check("t5_done", done, 1);

        // Watchdog behaviour with no stream traffic
`ifdef HISTEQ_SEQ_TIMEOUT_EN
        sb.push_back('{done: 1'b0, err: 1'b1, code: 3'd4, ic: 32'd0, oc: 32'd0});
        start(32'd4);
        step(0, 0, 0, 0);
        begin
            int k;
            k = 0;
            while (!err && k < 200) begin
                @(negedge clk);
                k++;
            end
            check("t6_timeout_latency", k, 100);
            check("t6_code", err_code, 4);
        end
`else
        sb.push_back('{done: 1'b0, err: 1'b1, code: 3'd5, ic: 32'd0, oc: 32'd0});
        start(32'd4);
        repeat (150) step(0, 0, 0, 0);
        check("t6_still_busy", busy, 1);
        check("t6_no_err", err, 0);
        cmd_abort = 1'b1;
        @(negedge clk);
        cmd_abort = 1'b0;
        wait_irq(4);
`endif

        // Asynchronous reset mid-frame
        start(32'd10);
        check("t7_core_start_arm", core_start, 1);
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        check("t7_counting", in_count, 2);
        #2 reset_n = 1'b0;
        #1;
        check("t7_rst_busy", busy, 0);
        check("t7_rst_counts", in_count | out_count, 0);
        check("t7_rst_total", core_total_pixels, 0);
        check("t7_rst_core_start", core_start, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
